wb_spraid_n: RTL and testbench
==============================

# wb_spraid_n

Parametrised successor to the four-channel Wishbone SPI array controller. It sits behind the Caravel Wishbone slave port in the user wrapper and drives `NUM_CH` SPI mode-0 master lanes on the IO pads. All lanes shift in lockstep from one clock divider. Two modes are supported:

- **mirror**: the same byte goes to every enabled lane, and the read-back bytes are compared.
- **stripe**: one byte per lane.

## Interface
Parameters:
- `NUM_CH`, 4: SPI lane count, legal range 1..4 (one byte per lane in the 32-bit data word).
- `DIV_W`, 8: clock-divider register width.

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- `wb_clk_i` input 1: system clock.
- `wb_rst_i` input 1: asynchronous, active-high reset.
- `wb_stb_i` input 1: Wishbone strobe.
- `wb_cyc_i` input 1: Wishbone cycle.
- `wb_we_i` input 1: Wishbone write enable.
- `wb_sel_i` input 4: byte select, ignored.
- `wb_adr_i` input 32: address; bits [3:2] decode the register.
- `wb_dat_i` input 32: write data.
- `wb_ack_o` output 1: single-cycle acknowledge.
- `wb_dat_o` output 32: read data.
- `spi_clk` output `NUM_CH`: SCLK per lane.
- `spi_cs` output `NUM_CH`: chip select per lane, active low.
- `spi_mosi` output `NUM_CH`: MOSI per lane.
- `spi_miso` input `NUM_CH`: MISO per lane.

## Operation
Registers (offset by `wb_adr_i[3:2]`):
- **0x0 CTRL**, reset value 0x0000_0F00 (mask bits above `NUM_CH` read 0):
  - [0] mode: 0 = mirror, 1 = stripe.
  - [1] cs_hold.
  - [8+NUM_CH-1:8] lane enable mask.
- **0x4 DIV**, reset value 0: SCLK half-period is DIV+1 clocks.
- **0x8 DATA**:
  - A write starts a transfer when the block is idle.
  - A write while busy is dropped and sets OVR.
  - A read returns the RX word; bytes above `NUM_CH` read 0.
- **0xC STATUS**, read/write-1-to-clear, reset value 0:
  - [0] BUSY, read-only.
  - [1] MISMATCH, sticky.
  - [2] OVR, sticky.

Transfer start:
- Mode, mask and DIV are snapshotted when the transfer starts.
- Later CTRL/DIV writes take effect on the next transfer.

Stripe mode:
- Lane k sends TX[8k+7:8k] and returns its byte in RX[8k+7:8k].

Mirror mode:
- Every enabled lane sends TX[7:0].
- RX[7:0] is taken from the lowest enabled lane; the other RX bytes are 0.
- MISMATCH is set if any enabled lane's received byte differs from that lane's byte.

Disabled lanes:
- CS stays 1, SCLK 0, MOSI 0; RX byte is 0.
- Disabled lanes are excluded from the mismatch comparison.
- A mask of 0 still runs full transfer timing; no pin toggles, and RX becomes 0.

SPI format:
- CPOL=0, CPHA=0, MSB first.
- MOSI changes on the SCLK falling edge; MISO is sampled at the SCLK rising edge.

State machine:
- IDLE → SETUP on a DATA write. In SETUP, CS is low and MOSI carries bit 7; duration is 1 half-period.
- SHIFT: 16 half-periods, 8 rising edges.
- HOLD: 1 half-period, SCLK low.
- HOLD → IDLE. On entering IDLE, CS returns high unless cs_hold=1. With cs_hold=1, CS stays low until cs_hold is written 0.

Reset (asynchronous, including mid-transfer):
- Immediately forces IDLE.
- CS all 1, SCLK 0, MOSI 0.
- `wb_ack_o` 0, `wb_dat_o` 0.
- All registers to their reset values; the RX word to 0.

## Timing
- `wb_ack_o` rises the cycle after `wb_stb_i & wb_cyc_i` is sampled high, for exactly one cycle. It is deasserted for at least one cycle before the next ack.
- `wb_dat_o` is valid in the ack cycle.
- BUSY is 1 from the ack cycle of the DATA write.
- BUSY stays high for 18·(DIV+1) cycles.
- RX and MISMATCH update in the last BUSY cycle, so they are readable on the first read issued after BUSY falls.
- The minimum period between transfers is 18·(DIV+1)+1 cycles.
- If a STATUS write-1-to-clear of MISMATCH coincides with a new mismatch, set wins.

## Structure
- Package `spraid_pkg`:
  - register offsets
  - state enum (IDLE, SETUP, SHIFT, HOLD)
  - mode constants (MODE_MIRROR, MODE_STRIPE)
  - bit positions of the CTRL and STATUS fields
- Sub-module `spraid_lane`, instantiated `NUM_CH` times by generate:
  - 8-bit shift register, MISO sampling, enable gating.
  - Driven by shared `load`, `rise` and `fall` strobes from the top-level divider/FSM.
- The top level holds the Wishbone decode, the registers, the divider counter, the FSM and the mismatch compare.

## Test plan
- **Stripe loopback**: mask=0xF, DIV=0, DATA←0xA55A_3CC3 with MISO looped to MOSI per lane → RX=0xA55A_3CC3; BUSY high for 18 cycles; lane 0 shifts out 1100_0011 MSB first.
- **Mirror with fault**: lane 2 MISO forced to 0x00 while the others loop back 0x96 → RX=0x0000_0096 and MISMATCH=1. Writing STATUS←0x2 clears it.
- **Overrun**: DIV=3, DATA write, then a second DATA write 10 cycles later → OVR=1; the first transfer completes unchanged in 72 cycles.
- **Partial mask**: mask=0x5, stripe, DATA←0x4433_2211 → lanes 1 and 3 show CS=1 and SCLK=0 throughout; RX=0x0033_0011.
- **cs_hold**: two back-to-back transfers with cs_hold=1 → CS stays low between them; it goes high the cycle after CTRL is written with cs_hold=0.
- **Mid-transfer reset**: assert `wb_rst_i` during SHIFT → CS=1, SCLK=0 in the same cycle; after release all registers read their reset values.

Source files
------------

// File: rtl/spraid_pkg.sv
// spraid_pkg: shared definitions for the Wishbone SPI array controller.
//   - register word offsets (decoded from wb_adr_i[3:2])
//   - transfer state enum
//   - mode encodings
//   - bit positions of the CTRL and STATUS fields
package spraid_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DIV    = 2'd1;
   localparam logic [1:0] ADDR_DATA   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic MODE_MIRROR = 1'b0;
   localparam logic MODE_STRIPE = 1'b1;

   localparam int CTRL_MODE_BIT = 0;
   localparam int CTRL_HOLD_BIT = 1;
   localparam int CTRL_MASK_LSB = 8;

   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_MISM_BIT = 1;
   localparam int STAT_OVR_BIT  = 2;

endpackage

// File: rtl/spraid_lane.sv
// spraid_lane: one SPI mode-0 lane of the array.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              lane enable (snapshot of the mask for this transfer)
//   load            load tx_byte and present its MSB on MOSI
//   rise            SCLK rising edge strobe: sample MISO into the shift register
//   fall            SCLK falling edge strobe: present the next bit on MOSI
//   done            end of transfer: park MOSI low
//   sclk, cs_low    shared SCLK level and chip-select request from the top
//   tx_byte         byte to send
//   miso            serial input
//   rx_byte         received byte (0 when disabled)
//   spi_clk/spi_cs/spi_mosi  gated pin drivers
import spraid_pkg::*;

module spraid_lane (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic       rise,
   input  logic       fall,
   input  logic       done,
   input  logic       sclk,
   input  logic       cs_low,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic [7:0] rx_byte,
   output logic       spi_clk,
   output logic       spi_cs,
   output logic       spi_mosi
);

   logic [7:0] shift_reg;
   logic       mosi_reg;

   // One register serves both directions: each rising edge pushes the
   // sampled MISO bit in at the bottom, which moves the next TX bit to
   // the top where the following falling edge picks it up for MOSI.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         mosi_reg  <= 1'b0;
      end else if (load) begin
         shift_reg <= tx_byte;
         mosi_reg  <= tx_byte[7];
      end else begin
         if (rise)
            shift_reg <= {shift_reg[6:0], miso};
         if (fall)
            mosi_reg <= shift_reg[7];
         if (done)
            mosi_reg <= 1'b0;
      end
   end

   assign rx_byte  = en ? shift_reg : 8'h00;
   assign spi_clk  = en & sclk;
   assign spi_cs   = ~(en & cs_low);
   assign spi_mosi = en & mosi_reg;

endmodule

// File: rtl/wb_spraid_n.sv
// wb_spraid_n: Wishbone slave driving NUM_CH lock-stepped SPI mode-0 lanes.
// Registers (wb_adr_i[3:2]): CTRL, DIV, DATA, STATUS.
// Ports:
//   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//   wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i (ignored), wb_adr_i, wb_dat_i
//   wb_ack_o                   single-cycle acknowledge
//   wb_dat_o                   read data, valid in the ack cycle
//   spi_clk, spi_cs, spi_mosi  per-lane SPI outputs (CS active low)
//   spi_miso                   per-lane SPI input
import spraid_pkg::*;

module wb_spraid_n #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wb_stb_i,
   input  logic              wb_cyc_i,
   input  logic              wb_we_i,
   input  logic [3:0]        wb_sel_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   output logic              wb_ack_o,
   output logic [31:0]       wb_dat_o,
   output logic [NUM_CH-1:0] spi_clk,
   output logic [NUM_CH-1:0] spi_cs,
   output logic [NUM_CH-1:0] spi_mosi,
   input  logic [NUM_CH-1:0] spi_miso
);

   state_t              state_reg;
   logic [DIV_W-1:0]    div_reg, div_snap_reg, cnt_reg;
   logic [3:0]          hp_reg;
   logic                mode_reg, cs_hold_reg, mode_snap_reg;
   logic [NUM_CH-1:0]   mask_reg, en_snap_reg;
   logic                sclk_reg, cs_low_reg;
   logic                ack_reg, mism_reg, ovr_reg;
   logic [31:0]         rx_reg, dat_reg;

   logic [31:0]         rdata, rx_next;
   logic [NUM_CH-1:0][7:0] tx_lane, rx_lane;
   logic [7:0]          ref_byte;
   logic                found, mism_now;

   logic unused_bits;
   assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};

   // Bus decode; the ~ack term guarantees a gap cycle between acks.
   logic       req, wr, busy;
   logic [1:0] addr;
   logic       wr_ctrl, wr_div, wr_data, wr_status;

   assign req       = wb_stb_i & wb_cyc_i & ~ack_reg;
   assign wr        = req & wb_we_i;
   assign addr      = wb_adr_i[3:2];
   assign wr_ctrl   = wr && (addr == ADDR_CTRL);
   assign wr_div    = wr && (addr == ADDR_DIV);
   assign wr_data   = wr && (addr == ADDR_DATA);
   assign wr_status = wr && (addr == ADDR_STATUS);
   assign busy      = (state_reg != IDLE);

   // Half-period strobes. SHIFT half-periods alternate high (even) / low
   // (odd). The fall into the final low half-period is suppressed so MOSI
   // keeps bit 0 instead of exposing received data.
   logic hp_end, load, rise, fall, done;
   assign hp_end = (cnt_reg == div_snap_reg);
   assign load   = wr_data & ~busy;
   assign rise   = hp_end & ((state_reg == SETUP) |
                             ((state_reg == SHIFT) & hp_reg[0] & (hp_reg != 4'd15)));
   assign fall   = hp_end & (state_reg == SHIFT) & ~hp_reg[0] & (hp_reg != 4'd14);
   assign done   = hp_end & (state_reg == HOLD);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
         assign tx_lane[gi] = (mode_reg == MODE_STRIPE) ? wb_dat_i[8*gi +: 8]
                                                        : wb_dat_i[7:0];
         spraid_lane u_lane (
            .clk      (wb_clk_i),
            .rst      (wb_rst_i),
            .en       (en_snap_reg[gi]),
            .load     (load),
            .rise     (rise),
            .fall     (fall),
            .done     (done),
            .sclk     (sclk_reg),
            .cs_low   (cs_low_reg),
            .tx_byte  (tx_lane[gi]),
            .miso     (spi_miso[gi]),
            .rx_byte  (rx_lane[gi]),
            .spi_clk  (spi_clk[gi]),
            .spi_cs   (spi_cs[gi]),
            .spi_mosi (spi_mosi[gi])
         );
      end
   endgenerate

   // RX assembly and mirror compare. Disabled lanes already read 0 and are
   // skipped; the lowest enabled lane is the mirror reference.
   always_comb begin
      ref_byte = 8'h00;
      found    = 1'b0;
      mism_now = 1'b0;
      rx_next  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (en_snap_reg[k] && !found) begin
            ref_byte = rx_lane[k];
            found    = 1'b1;
         end
      end
      if (mode_snap_reg == MODE_STRIPE) begin
         for (int k = 0; k < NUM_CH; k++)
            rx_next[8*k +: 8] = rx_lane[k];
      end else begin
         rx_next[7:0] = ref_byte;
         for (int k = 0; k < NUM_CH; k++)
            if (en_snap_reg[k] && (rx_lane[k] != ref_byte))
               mism_now = 1'b1;
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_CTRL: begin
            rdata[CTRL_MODE_BIT]              = mode_reg;
            rdata[CTRL_HOLD_BIT]              = cs_hold_reg;
            rdata[CTRL_MASK_LSB +: NUM_CH]    = mask_reg;
         end
         ADDR_DIV:  rdata[DIV_W-1:0] = div_reg;
         ADDR_DATA: rdata = rx_reg;
         default: begin
            rdata[STAT_BUSY_BIT] = busy;
            rdata[STAT_MISM_BIT] = mism_reg;
            rdata[STAT_OVR_BIT]  = ovr_reg;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         hp_reg        <= '0;
         sclk_reg      <= 1'b0;
         cs_low_reg    <= 1'b0;
         mode_reg      <= MODE_MIRROR;
         cs_hold_reg   <= 1'b0;
         mask_reg      <= '1;
         div_reg       <= '0;
         mode_snap_reg <= MODE_MIRROR;
         en_snap_reg   <= '0;
         div_snap_reg  <= '0;
         rx_reg        <= '0;
         mism_reg      <= 1'b0;
         ovr_reg       <= 1'b0;
         ack_reg       <= 1'b0;
         dat_reg       <= '0;
      end else begin
         ack_reg <= req;
         dat_reg <= (req && !wb_we_i) ? rdata : '0;

         if (wr_ctrl) begin
            mode_reg    <= wb_dat_i[CTRL_MODE_BIT];
            cs_hold_reg <= wb_dat_i[CTRL_HOLD_BIT];
            mask_reg    <= wb_dat_i[CTRL_MASK_LSB +: NUM_CH];
         end
         if (wr_div)
            div_reg <= wb_dat_i[DIV_W-1:0];

         // Sticky flags: a coincident set beats the write-1-to-clear.
         ovr_reg  <= (ovr_reg  & ~(wr_status & wb_dat_i[STAT_OVR_BIT]))  | (wr_data & busy);
         mism_reg <= (mism_reg & ~(wr_status & wb_dat_i[STAT_MISM_BIT])) | (done & mism_now);

         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               hp_reg  <= '0;
               if (wr_data) begin
                  state_reg     <= SETUP;
                  mode_snap_reg <= mode_reg;
                  en_snap_reg   <= mask_reg;
                  div_snap_reg  <= div_reg;
                  cs_low_reg    <= 1'b1;
               end else if (!cs_hold_reg) begin
                  cs_low_reg <= 1'b0;
               end
            end
            SETUP: begin
               if (hp_end) begin
                  cnt_reg   <= '0;
                  state_reg <= SHIFT;
                  sclk_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            SHIFT: begin
               if (hp_end) begin
                  cnt_reg <= '0;
                  if (hp_reg == 4'd15) begin
                     state_reg <= HOLD;
                  end else begin
                     hp_reg   <= hp_reg + 4'd1;
                     sclk_reg <= hp_reg[0];   // next half-period even -> high
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            HOLD: begin
               if (hp_end) begin
                  cnt_reg    <= '0;
                  state_reg  <= IDLE;
                  rx_reg     <= rx_next;
                  cs_low_reg <= cs_hold_reg;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign wb_ack_o = ack_reg;
   assign wb_dat_o = dat_reg;

endmodule

// File: tb/tb_wb_spraid_n.sv
module tb_wb_spraid_n;

   localparam int NUM_CH = 4;

   logic              wb_clk_i = 1'b0;
   logic              wb_rst_i = 1'b1;
   logic              wb_stb_i = 1'b0;
   logic              wb_cyc_i = 1'b0;
   logic              wb_we_i  = 1'b0;
   logic [3:0]        wb_sel_i = 4'hF;
   logic [31:0]       wb_adr_i = '0;
   logic [31:0]       wb_dat_i = '0;
   logic              wb_ack_o;
   logic [31:0]       wb_dat_o;
   logic [NUM_CH-1:0] spi_clk, spi_cs, spi_mosi, spi_miso;
   logic [NUM_CH-1:0] force_zero = '0;

   int checks   = 0;
   int failures = 0;

   // monitor state
   int         cs_low_cyc  = 0;
   int         cs_high_cyc = 0;
   int         l0_rises    = 0;
   int         dis_viol    = 0;
   logic [7:0] l0_bits     = 8'h00;
   logic       sclk0_prev  = 1'b0;

   logic [31:0] rd;

   assign spi_miso = spi_mosi & ~force_zero;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_spraid_n #(.NUM_CH(NUM_CH), .DIV_W(8)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_we_i  (wb_we_i),
      .wb_sel_i (wb_sel_i),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_ack_o (wb_ack_o),
      .wb_dat_o (wb_dat_o),
      .spi_clk  (spi_clk),
      .spi_cs   (spi_cs),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
   );

   always @(posedge wb_clk_i) begin
      #1;
      if (!spi_cs[0]) cs_low_cyc++; else cs_high_cyc++;
      if (spi_clk[0] && !sclk0_prev) begin
         l0_bits = {l0_bits[6:0], spi_mosi[0]};
         l0_rises++;
      end
      sclk0_prev = spi_clk[0];
      if (!spi_cs[1] || !spi_cs[3] || spi_clk[1] || spi_clk[3] || spi_mosi[1] || spi_mosi[3])
         dis_viol++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          output logic [31:0] rdat);
      logic got;
      got = 1'b0;
      @(posedge wb_clk_i); #1;
      wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge wb_clk_i); #1;
         if (wb_ack_o) got = 1'b1;
      end
      rdat = wb_dat_o;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      if (!got) check_eq("ack_timeout", 32'(got), 32'd1);
      $display("WB %s adr=%h dat=%h", we ? "WR" : "RD", adr, we ? wdat : rdat);
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
      logic [31:0] dummy;
      wb_xfer(1'b1, adr, wdat, dummy);
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
      wb_xfer(1'b0, adr, 32'h0, rdat);
   endtask

   task automatic clear_mon();
      cs_low_cyc = 0; cs_high_cyc = 0; l0_rises = 0; dis_viol = 0; l0_bits = 8'h00;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge wb_clk_i);
      #2;
   endtask

   initial begin
      // ---------------- reset state ----------------
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i); wb_rst_i = 1'b0;
      #1;
      check_eq("rst_cs",   32'(spi_cs),   32'hF);
      check_eq("rst_sclk", 32'(spi_clk),  32'h0);
      check_eq("rst_ack",  32'(wb_ack_o), 32'h0);
      wb_read(32'h0, rd);  check_eq("rst_ctrl",   rd, 32'h0000_0F00);
      wb_read(32'h4, rd);  check_eq("rst_div",    rd, 32'h0);
      wb_read(32'h8, rd);  check_eq("rst_data",   rd, 32'h0);
      wb_read(32'hC, rd);  check_eq("rst_status", rd, 32'h0);

      // ---------------- stripe loopback, DIV=0 ----------------
      wb_write(32'h0, 32'h0000_0F01);
      wb_write(32'h4, 32'h0);
      clear_mon();
      wb_write(32'h8, 32'hA55A_3CC3);
      wb_read(32'hC, rd);  check_eq("stripe_busy", rd, 32'h1);
      wait_cyc(30);
      check_eq("stripe_cs_cycles", 32'(cs_low_cyc), 32'd18);
      check_eq("stripe_rises",     32'(l0_rises),   32'd8);
      check_eq("stripe_lane0_bits", 32'(l0_bits),   32'hC3);
      wb_read(32'h8, rd);  check_eq("stripe_rx",     rd, 32'hA55A_3CC3);
      wb_read(32'hC, rd);  check_eq("stripe_status", rd, 32'h0);

      // ---------------- mirror with lane 2 fault ----------------
      wb_write(32'h0, 32'h0000_0F00);
      force_zero = 4'b0100;
      wb_write(32'h8, 32'h0000_0096);
      wait_cyc(30);
      wb_read(32'h8, rd);  check_eq("mirror_rx",     rd, 32'h0000_0096);
      wb_read(32'hC, rd);  check_eq("mirror_status", rd, 32'h2);
      wb_write(32'hC, 32'h2);
      wb_read(32'hC, rd);  check_eq("mirror_clear",  rd, 32'h0);
      force_zero = 4'b0000;

      // ---------------- overrun, DIV=3 ----------------
      wb_write(32'h0, 32'h0000_0F01);
      wb_write(32'h4, 32'h3);
      clear_mon();
      wb_write(32'h8, 32'h1234_5678);
      repeat (8) @(posedge wb_clk_i);
      wb_write(32'h8, 32'hFFFF_FFFF);
      wait_cyc(80);
      check_eq("ovr_cs_cycles", 32'(cs_low_cyc), 32'd72);
      check_eq("ovr_lane0_bits", 32'(l0_bits),   32'h78);
      wb_read(32'h8, rd);  check_eq("ovr_rx",     rd, 32'h1234_5678);
      wb_read(32'hC, rd);  check_eq("ovr_status", rd, 32'h4);
      wb_write(32'hC, 32'h4);

      // ---------------- partial mask 0x5, stripe ----------------
      wb_write(32'h4, 32'h0);
      wb_write(32'h0, 32'h0000_0501);
      wb_read(32'h0, rd);  check_eq("mask_ctrl", rd, 32'h0000_0501);
      clear_mon();
      wb_write(32'h8, 32'h4433_2211);
      wait_cyc(30);
      check_eq("mask_disabled_pins", 32'(dis_viol),   32'd0);
      check_eq("mask_cs_cycles",     32'(cs_low_cyc), 32'd18);
      check_eq("mask_lane0_bits",    32'(l0_bits),    32'h11);
      wb_read(32'h8, rd);  check_eq("mask_rx", rd, 32'h0033_0011);

      // ---------------- cs_hold ----------------
      wb_write(32'h0, 32'h0000_0F03);
      wb_write(32'h8, 32'h0102_0304);
      clear_mon();
      wait_cyc(30);
      check_eq("hold_cs_after1", 32'(spi_cs), 32'h0);
      wb_read(32'h8, rd);  check_eq("hold_rx1", rd, 32'h0102_0304);
      wb_write(32'h8, 32'h0A0B_0C0D);
      wait_cyc(30);
      check_eq("hold_cs_high_cycles", 32'(cs_high_cyc), 32'd0);
      wb_read(32'h8, rd);  check_eq("hold_rx2", rd, 32'h0A0B_0C0D);
      wb_write(32'h0, 32'h0000_0F01);
      @(posedge wb_clk_i); #1;
      check_eq("hold_release_cs", 32'(spi_cs), 32'hF);

      // ---------------- mid-transfer reset ----------------
      wb_write(32'h4, 32'h5);
      wb_write(32'h8, 32'hDEAD_BEEF);
      repeat (20) @(posedge wb_clk_i);
      #3;
      check_eq("midrst_pre_cs0", 32'(spi_cs[0]), 32'h0);
      wb_rst_i = 1'b1;
      #1;
      check_eq("midrst_cs",   32'(spi_cs),   32'hF);
      check_eq("midrst_sclk", 32'(spi_clk),  32'h0);
      check_eq("midrst_mosi", 32'(spi_mosi), 32'h0);
      @(posedge wb_clk_i);
      @(negedge wb_clk_i); wb_rst_i = 1'b0;
      wb_read(32'h0, rd);  check_eq("midrst_ctrl",   rd, 32'h0000_0F00);
      wb_read(32'h4, rd);  check_eq("midrst_div",    rd, 32'h0);
      wb_read(32'h8, rd);  check_eq("midrst_data",   rd, 32'h0);
      wb_read(32'hC, rd);  check_eq("midrst_status", rd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
